// File: rtl/fft_axis_framer.sv
// fft_axis_framer: AXI4-Stream framer in front of the FFT sample input.
// Buffers an unframed sample stream in a small first-word fall-through FIFO
// and emits num_frames frames of FRAME_LEN beats, with TLAST on each frame's final beat.
// Optional start-of-frame marker on m_axis_tuser when FFT_AXIS_FRAMER_TUSER_EN is defined.
module fft_axis_framer #(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned FRAME_LEN  = 1024,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              start,
  input  logic [15:0]       num_frames,
  output logic              busy,
  output logic              done,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast
`ifdef FFT_AXIS_FRAMER_TUSER_EN
  ,
  output logic              m_axis_tuser
`endif
);

  localparam int unsigned BeatW = $clog2(FRAME_LEN);
  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam logic [BeatW-1:0] BeatLast = BeatW'(FRAME_LEN - 1);
  localparam logic [CntW-1:0]  OccFull  = CntW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

  state_e state_q, state_d;
  logic   busy_q, busy_d;
  logic   done_q, done_d;

  logic [31:0] total_q, total_d;
  logic [31:0] in_cnt_q, in_cnt_d;
  logic [31:0] out_cnt_q, out_cnt_d;
  logic [BeatW-1:0] beat_idx_q, beat_idx_d;

  // Storage behind the output register; the output register counts as one entry.
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   mem_cnt_q, mem_cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;

  logic [CntW-1:0] occupancy;
  logic            fifo_full, fifo_empty;
  logic            push, pop, load, job_start;

  // Handshake and FIFO status decode, all from registered state
  always_comb begin
    occupancy  = mem_cnt_q + CntW'(out_valid_q);
    fifo_full  = (occupancy == OccFull);
    fifo_empty = (occupancy == '0);
    s_ready    = (state_q == StRun) && !fifo_full && (in_cnt_q < total_q);
    push       = s_valid && s_ready;
    pop        = out_valid_q && m_axis_tready;
    // Refill the output register when it is empty or being drained this cycle
    load       = (mem_cnt_q != '0) && (!out_valid_q || pop);
    job_start  = (state_q == StIdle) && start;
  end

  // Job FSM next-state and control outputs
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    total_d = total_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          total_d = 32'(num_frames) * 32'(FRAME_LEN);
          busy_d  = 1'b1;
          state_d = (num_frames != 16'd0) ? StRun : StFlush;
        end
      end
      StRun: begin
        if (in_cnt_q == total_q) begin
          state_d = StFlush;
        end
      end
      StFlush: begin
        if ((out_cnt_q == total_q) && fifo_empty) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Counter and output-register next-state
  always_comb begin
    in_cnt_d    = in_cnt_q;
    out_cnt_d   = out_cnt_q;
    beat_idx_d  = beat_idx_q;
    mem_cnt_d   = mem_cnt_q + CntW'(push) - CntW'(load);
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (job_start) begin
      in_cnt_d   = '0;
      out_cnt_d  = '0;
      beat_idx_d = '0;
    end else begin
      in_cnt_d = in_cnt_q + 32'(push);
      if (pop) begin
        out_cnt_d  = out_cnt_q + 32'd1;
        // Power-of-two frame length: natural wrap returns to 0 after TLAST
        beat_idx_d = beat_idx_q + BeatW'(1);
      end
    end
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = mem_q[rd_ptr_q];
    end else if (pop) begin
      out_valid_d = 1'b0;
    end
  end

  // Control and counter state registers
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q     <= StIdle;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      total_q     <= '0;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      beat_idx_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      total_q     <= total_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      beat_idx_q  <= beat_idx_d;
      mem_cnt_q   <= mem_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (load) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset
  always_ff @(posedge ap_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= s_data;
    end
  end

  // Output drive; framing flags derive from registered valid and beat index
  always_comb begin
    busy          = busy_q;
    done          = done_q;
    m_axis_tdata  = out_data_q;
    m_axis_tvalid = out_valid_q;
    m_axis_tlast  = out_valid_q && (beat_idx_q == BeatLast);
`ifdef FFT_AXIS_FRAMER_TUSER_EN
    m_axis_tuser  = out_valid_q && (beat_idx_q == '0);
`endif
  end

endmodule

// File: tb/tb_fft_axis_framer.sv
// tb_fft_axis_framer: directed + randomized check of fft_axis_framer against
// a queue-based reference (accepted samples must reappear in order, framed).
`timescale 1ns/1ps
module tb_fft_axis_framer;
  localparam int unsigned DATA_W     = 64;
  localparam int unsigned FRAME_LEN  = 8;
  localparam int unsigned FIFO_DEPTH = 4;

  logic              ap_clk = 1'b0;
  logic              ap_rst = 1'b1;
  logic              start = 1'b0;
  logic [15:0]       num_frames = '0;
  logic              busy, done;
  logic [DATA_W-1:0] s_data = '0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [DATA_W-1:0] m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready = 1'b0;
  logic              m_axis_tlast;
`ifdef FFT_AXIS_FRAMER_TUSER_EN
  logic              m_axis_tuser;
`endif

  int vectors = 0;
  int miscompares = 0;

  fft_axis_framer #(
    .DATA_W    (DATA_W),
    .FRAME_LEN (FRAME_LEN),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .ap_clk       (ap_clk),
    .ap_rst       (ap_rst),
    .start        (start),
    .num_frames   (num_frames),
    .busy         (busy),
    .done         (done),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast)
`ifdef FFT_AXIS_FRAMER_TUSER_EN
    ,
    .m_axis_tuser (m_axis_tuser)
`endif
  );

  always #5 ap_clk = ~ap_clk;

  // Monitor state, sampled on the falling edge
  int          cyc = 0;
  logic [63:0] out_q[$];
  bit          last_q[$];
  bit          user_q[$];
  int          beat_cyc_q[$];
  int          acc_cnt, done_cnt, done_cyc, busy_at_done;
  int          sready_cnt, tvalid_cnt, first_acc_cyc, first_tv_cyc, viol;
  bit          hold_pend;
  logic [63:0] hold_data;
  bit          hold_last, hold_user;

  always @(posedge ap_clk) cyc <= cyc + 1;

  always @(negedge ap_clk) begin
    if (ap_rst) begin
      hold_pend = 1'b0;
    end else begin
      bit cur_user;
      cur_user = 1'b0;
`ifdef FFT_AXIS_FRAMER_TUSER_EN
      cur_user = m_axis_tuser;
`endif
      if (hold_pend && (!m_axis_tvalid || m_axis_tdata !== hold_data ||
                        m_axis_tlast !== hold_last || cur_user !== hold_user)) viol++;
      hold_pend = m_axis_tvalid && !m_axis_tready;
      hold_data = m_axis_tdata;
      hold_last = m_axis_tlast;
      hold_user = cur_user;
      if (s_valid && s_ready) begin
        if (first_acc_cyc < 0) first_acc_cyc = cyc;
        acc_cnt++;
      end
      if (m_axis_tvalid && first_tv_cyc < 0) first_tv_cyc = cyc;
      if (m_axis_tvalid && m_axis_tready) begin
        out_q.push_back(m_axis_tdata);
        last_q.push_back(m_axis_tlast);
        user_q.push_back(cur_user);
        beat_cyc_q.push_back(cyc);
      end
      if (done) begin
        done_cnt++;
        done_cyc     = cyc;
        busy_at_done = int'(busy);
      end
      if (s_ready) sready_cnt++;
      if (m_axis_tvalid) tvalid_cnt++;
    end
  end

  task automatic clear_mon();
    out_q.delete(); last_q.delete(); user_q.delete(); beat_cyc_q.delete();
    acc_cnt = 0; done_cnt = 0; done_cyc = -1; busy_at_done = -1;
    sready_cnt = 0; tvalid_cnt = 0; first_acc_cyc = -1; first_tv_cyc = -1; viol = 0;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One job: nf frames, random valid/ready percentages, tready held low for the
  // first 'stall' cycles, sequential or random data, optional stray start.
  task automatic run_job(input int nf, input int vpct, input int rpct, input int stall,
                         input bit seq, input int late_start);
    logic [63:0] exp_q[$];
    logic [63:0] val;
    int          n, beats_exp, acc_snap;
    logic        sr_snap, tv_snap;
    logic [63:0] td_snap;
    acc_snap = -1; sr_snap = 1'bx; tv_snap = 1'bx; td_snap = 'x;
    clear_mon();
    beats_exp = nf * int'(FRAME_LEN);
    val = seq ? 64'd0 : {$urandom, $urandom};
    start = 1'b1; num_frames = 16'(nf); s_valid = 1'b0; m_axis_tready = 1'b0;
    @(posedge ap_clk); #1;
    start = 1'b0;
    n = 0;
    while (done_cnt == 0 && n < 4000) begin
      if (stall > 0 && n == stall) begin
        acc_snap = exp_q.size(); sr_snap = s_ready; tv_snap = m_axis_tvalid; td_snap = m_axis_tdata;
      end
      s_valid       = ($urandom_range(99) < vpct);
      m_axis_tready = (n >= stall) && ($urandom_range(99) < rpct);
      s_data        = val;
      start         = (n == late_start);
      if (start) num_frames = 16'd5;
      if (s_valid && s_ready) begin
        exp_q.push_back(val);
        val = seq ? val + 64'd1 : {$urandom, $urandom};
      end
      @(posedge ap_clk); #1;
      n++;
    end
    start = 1'b0;
    check("done_seen", done_cnt, 1);
    if (stall >= int'(FIFO_DEPTH) + 2) begin
      check("stall_accepts", acc_snap, FIFO_DEPTH);
      check("stall_sready", sr_snap, 0);
      check("stall_tvalid", tv_snap, 1);
      check("stall_tdata", td_snap, exp_q[0]);
    end
    check("accepted_cnt", exp_q.size(), beats_exp);
    check("beat_cnt", out_q.size(), beats_exp);
    for (int i = 0; i < out_q.size(); i++) begin
      check($sformatf("data[%0d]", i), out_q[i], (i < exp_q.size()) ? exp_q[i] : 'x);
      check($sformatf("tlast[%0d]", i), last_q[i], (i % int'(FRAME_LEN)) == int'(FRAME_LEN) - 1);
`ifdef FFT_AXIS_FRAMER_TUSER_EN
      check($sformatf("tuser[%0d]", i), user_q[i], (i % int'(FRAME_LEN)) == 0);
`endif
    end
    check("hold_violations", viol, 0);
    if (vpct == 100 && rpct == 100 && stall == 0 && nf > 0) begin
      check("first_beat_latency", first_tv_cyc - first_acc_cyc, 2);
      check("throughput_span", beat_cyc_q[$] - beat_cyc_q[0], beats_exp - 1);
      check("done_latency", done_cyc - beat_cyc_q[$], 2);
      check("busy_at_done", busy_at_done, 0);
    end
    // Keep offering input after the job: nothing more may be accepted
    s_valid = 1'b1; m_axis_tready = 1'b1;
    repeat (3) begin @(posedge ap_clk); #1; end
    check("no_extra_accept", acc_cnt, beats_exp);
    check("done_single", done_cnt, 1);
    check("busy_after", busy, 0);
    check("sready_after", s_ready, 0);
    s_valid = 1'b0;
  endtask

  initial begin
    logic [63:0] val;
    int n;
    clear_mon();
    ap_rst = 1'b1;
    repeat (3) @(posedge ap_clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sready", s_ready, 0);
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tlast", m_axis_tlast, 0);
    check("rst_tdata", m_axis_tdata, 0);
    ap_rst = 1'b0;
    @(posedge ap_clk); #1;

    run_job(2, 100, 100, 0, 1'b1, -1);   // basic
    run_job(2, 100, 100, 10, 1'b1, -1);  // backpressure
    run_job(6, 50, 50, 0, 1'b0, -1);     // random stalls
    run_job(2, 100, 100, 3, 1'b0, -1);   // short stall

    // Zero frames
    clear_mon();
    start = 1'b1; num_frames = 16'd0; s_valid = 1'b1; m_axis_tready = 1'b1;
    @(posedge ap_clk); #1;
    start = 1'b0;
    check("zero_busy1", busy, 1);
    check("zero_done1", done, 0);
    @(posedge ap_clk); #1;
    check("zero_busy2", busy, 0);
    check("zero_done2", done, 1);
    @(posedge ap_clk); #1;
    check("zero_done3", done, 0);
    repeat (3) begin @(posedge ap_clk); #1; end
    check("zero_sready_cnt", sready_cnt, 0);
    check("zero_tvalid_cnt", tvalid_cnt, 0);
    check("zero_done_cnt", done_cnt, 1);
    s_valid = 1'b0;

    // Reset mid-frame
    clear_mon();
    start = 1'b1; num_frames = 16'd1; s_valid = 1'b1; m_axis_tready = 1'b1;
    val = 64'd0; s_data = val;
    @(posedge ap_clk); #1;
    start = 1'b0;
    n = 0;
    while (out_q.size() < 5 && n < 100) begin
      s_data = val;
      if (s_valid && s_ready) val = val + 64'd1;
      @(posedge ap_clk); #1;
      n++;
    end
    check("pre_reset_beats", out_q.size() >= 5, 1);
    #2 ap_rst = 1'b1;
    #1;
    check("arst_tvalid", m_axis_tvalid, 0);
    check("arst_tdata", m_axis_tdata, 0);
    check("arst_tlast", m_axis_tlast, 0);
    check("arst_busy", busy, 0);
    check("arst_sready", s_ready, 0);
    s_valid = 1'b0;
    @(posedge ap_clk); #1;
    ap_rst = 1'b0;
    @(posedge ap_clk); #1;
    run_job(1, 100, 100, 0, 1'b1, 3);    // fresh job with a stray start in RUN

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fft_axis_framer.md
Name: fft_axis_framer

Overview:
- AXI4-Stream transmitter feeding the FFT core's sample input (s_axis side of the FFT block design).
- Accepts an unframed complex-sample stream, buffers it in a small FIFO, and emits frames of exactly FRAME_LEN beats with TLAST on the final beat.
- Runs a job of num_frames frames per start pulse and pulses done when the last beat has left the block.

Parameters:
DATA_W, 64, sample width; {im[31:0], re[31:0]} single-precision pair
FRAME_LEN, 1024, beats per frame / FFT size; power of two, >= 2
FIFO_DEPTH, 16, skid FIFO entries; power of two, >= 2

Ports:
ap_clk  in  1  clock; all logic on the rising edge
ap_rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; sampled only in IDLE
num_frames  in  16  frames per job; latched on an accepted start
busy  out  1  high from an accepted start until done
done  out  1  one-cycle pulse at job completion
s_data  in  DATA_W  input sample
s_valid  in  1  input sample valid
s_ready  out  1  block can accept a sample
m_axis_tdata  out  DATA_W  output sample
m_axis_tvalid  out  1  output beat valid
m_axis_tready  in  1  downstream (FFT) ready
m_axis_tlast  out  1  last beat of the frame

Behaviour:
- Reset (async assert, released synchronously to ap_clk):
  - State IDLE.
  - FIFO empty; all counters 0.
  - busy, done, s_ready, m_axis_tvalid, m_axis_tlast all 0; m_axis_tdata 0.
  - Reset mid-job drops the job and all buffered data; nothing is resumed.
- FSM: IDLE -> RUN -> FLUSH -> IDLE.
  - IDLE:
    - start=1 latches total = num_frames * FRAME_LEN (32-bit product), clears counters, sets busy.
    - If num_frames != 0: go to RUN.
    - If num_frames == 0: go to FLUSH, giving busy=1 for one cycle, then a done pulse on the next cycle; no beats are emitted.
  - RUN:
    - Input accepted when s_valid && s_ready.
    - s_ready = (state==RUN) && !fifo_full && (in_cnt < total). Decided from registered state only; no combinational path from m_axis_tready.
    - When in_cnt reaches total: go to FLUSH.
  - FLUSH:
    - Drains the FIFO.
    - When out_cnt == total and the FIFO is empty: done=1 for one cycle, busy=0, go to IDLE.
  - start is ignored outside IDLE.
- FIFO:
  - Registered output, first-word fall-through.
  - A sample accepted at edge k is visible on m_axis_tvalid/tdata after edge k+1 (latency 1) if the FIFO was empty.
  - Simultaneous push and pop in one cycle is allowed, including when FIFO_DEPTH-1 entries are occupied.
  - No push when full (s_ready already low). No pop when empty.
  - Sustained throughput: 1 beat/cycle when s_valid=1 and m_axis_tready=1.
- Output handshake:
  - Beat transfers when m_axis_tvalid && m_axis_tready.
  - tdata, tvalid and tlast are held stable while tvalid=1 and tready=0.
  - tvalid is never withdrawn without a transfer.
- Framing:
  - beat_idx counts transferred beats modulo FRAME_LEN.
  - m_axis_tlast = m_axis_tvalid && (beat_idx == FRAME_LEN-1).
  - beat_idx wraps to 0 after the TLAST beat.
  - out_cnt increments per transferred beat (32-bit).
- Arithmetic:
  - in_cnt and out_cnt are 32-bit.
  - total never exceeds 65535*FRAME_LEN; no overflow for FRAME_LEN <= 65536.

Optional Feature:
- Macro: FFT_AXIS_FRAMER_TUSER_EN.
- When defined:
  - Adds output port m_axis_tuser (1 bit).
  - m_axis_tuser = m_axis_tvalid && (beat_idx == 0), marking start of frame.
  - Reset value 0; held stable under backpressure like tdata.
- When undefined:
  - Port and logic are absent.
  - All other behaviour is identical.

Test Plan:
- Basic job: reset, FRAME_LEN=8, start with num_frames=2, s_valid=1 with data 0..15, m_axis_tready=1.
  - Expect 16 beats in order; tlast on beats 7 and 15 only.
  - First beat appears 1 cycle after the first accepted input.
  - done pulses once, 1 cycle after the final transfer; busy then drops.
- Backpressure: FRAME_LEN=8, FIFO_DEPTH=4, m_axis_tready=0 for 10 cycles.
  - s_ready drops after 4 accepts.
  - tdata=0 and tvalid stay stable throughout.
  - On release, data 0..15 arrive unchanged with correct tlast.
- Random stalls: random s_valid and m_axis_tready (50%), num_frames=3, FRAME_LEN=16.
  - Output equals input sequence; exactly 48 beats; tlast every 16th beat.
  - No input accepted beyond beat 48.
- Zero frames: start with num_frames=0.
  - No m_axis_tvalid, s_ready stays 0.
  - busy high 1 cycle; done pulses on the following cycle.
- Reset and start rules:
  - Assert ap_rst mid-frame after 5 of 8 beats: all outputs 0 immediately (asynchronously).
  - A fresh job of num_frames=1 then starts at beat_idx 0 with tlast on beat 7.
  - A start pulse during RUN is ignored.
- With FFT_AXIS_FRAMER_TUSER_EN defined, FRAME_LEN=4, num_frames=2:
  - m_axis_tuser=1 on beats 0 and 4 only, and held stable under a 3-cycle tready stall.
